// File: rtl/input_pulse_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press strobe and glitch counter.
// Optional auto-repeat of the press strobe while held: define AUTOREPEAT_EN.
module input_pulse_conditioner #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       glitch_clr,
  output logic       pulse,
  output logic       level,
  output logic [3:0] glitch_cnt
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned GLITCH_W = 4;
  localparam logic [CNT_W-1:0]    DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_deb_range
    $error("DEB_CYCLES must be in 2..255");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 || HOLD_CYCLES + REPEAT_CYCLES > 65535) begin : g_hold_range
    $error("HOLD_CYCLES/REPEAT_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, RISE_CHK, HIGH, FALL_CHK} state_t;

  state_t           state, state_nxt;
  logic             s1, s2;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             glitch_inc;
  logic             press_acc;
  logic             repeat_hit;
  logic             pulse_nxt, level_nxt;

  // Two-flop synchronizer; only s2 is used by the logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (s2) begin
        state_nxt = RISE_CHK;
        cnt_nxt   = CNT_W'(1);
      end
      RISE_CHK: begin
        if (!s2)                  state_nxt = IDLE;
        else if (cnt == DEB_LAST) state_nxt = HIGH;
        else                      cnt_nxt   = cnt + CNT_W'(1);
      end
      HIGH: if (!s2) begin
        state_nxt = FALL_CHK;
        cnt_nxt   = CNT_W'(1);
      end
      FALL_CHK: begin
        if (s2)                   state_nxt = HIGH;
        else if (cnt == DEB_LAST) state_nxt = IDLE;
        else                      cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    press_acc  = (state == RISE_CHK) && (state_nxt == HIGH);
    glitch_inc = ((state == RISE_CHK) && !s2) || ((state == FALL_CHK) && s2);
    pulse_nxt  = press_acc || repeat_hit;
    level_nxt  = (state_nxt == HIGH) || (state_nxt == FALL_CHK);
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned HOLD_W = 16;
  localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_WRAP  = HOLD_W'(HOLD_CYCLES + REPEAT_CYCLES);

  logic [HOLD_W-1:0] hold, hold_inc, hold_nxt;

  // Hold counter wraps back to HOLD_FIRST so every repeat lands on the same value.
  always_comb begin
    hold_inc   = hold + HOLD_W'(1);
    hold_nxt   = hold;
    repeat_hit = 1'b0;
    if (press_acc) begin
      hold_nxt = '0;
    end else if ((state == HIGH) && s2) begin
      hold_nxt   = (hold_inc == HOLD_WRAP) ? HOLD_FIRST : hold_inc;
      repeat_hit = (hold_nxt == HOLD_FIRST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hold <= '0;
    else       hold <= hold_nxt;
  end
`else
  assign repeat_hit = 1'b0;
`endif

  // Registered outputs; a clear beats a simultaneous increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse      <= 1'b0;
      level      <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      pulse <= pulse_nxt;
      level <= level_nxt;
      if (glitch_clr)
        glitch_cnt <= '0;
      else if (glitch_inc && (glitch_cnt != GLITCH_MAX))
        glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end

endmodule

// File: doc/input_pulse_conditioner.md
INPUT_PULSE_CONDITIONER -- requirements
Module: input_pulse_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive synchronized samples needed to accept a level change; legal range 2..255.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles in HIGH before the first auto-repeat pulse; used only when AUTOREPEAT_EN is defined.
REQ-003 Parameter REPEAT_CYCLES, default 8: cycles between auto-repeat pulses; used only when AUTOREPEAT_EN is defined.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_raw  input  1  asynchronous, bouncy push-button level.
REQ-007 glitch_clr  input  1  synchronous clear of glitch_cnt.
REQ-008 pulse  output  1  registered one-cycle press strobe; drives the downstream sequence detector's ain.
REQ-009 level  output  1  registered debounced button level.
REQ-010 glitch_cnt  output  4  saturating count of rejected bounces.

Function
REQ-011 btn_raw SHALL pass through a 2-flop synchronizer; only the second flop output (s2) feeds logic.
REQ-012 The FSM SHALL have four states: IDLE (level 0), RISE_CHK, HIGH (level 1), FALL_CHK; the debounce counter SHALL be 8 bits.
REQ-013 IDLE: s2=1 -> RISE_CHK with counter=1; otherwise stay.
REQ-014 RISE_CHK: s2=0 -> IDLE and glitch increment; s2=1 with counter=DEB_CYCLES-1 -> HIGH; otherwise counter+1.
REQ-015 HIGH: s2=0 -> FALL_CHK with counter=1; otherwise stay.
REQ-016 FALL_CHK: s2=1 -> HIGH and glitch increment; s2=0 with counter=DEB_CYCLES-1 -> IDLE; otherwise counter+1.
REQ-017 pulse SHALL be 1 for exactly the cycle after the RISE_CHK->HIGH edge; FALL_CHK->HIGH, HIGH->FALL_CHK and FALL_CHK->IDLE SHALL NOT pulse.
REQ-018 level SHALL be 1 exactly while the state is HIGH or FALL_CHK.
REQ-019 Latency SHALL follow from REQ-011 to REQ-016: for a clean rise first sampled at edge N, pulse and level SHALL rise after edge N+DEB_CYCLES+1.
REQ-020 With defaults and a clean rise first sampled at edge N, pulse and level SHALL rise after edge N+5.
REQ-021 glitch_cnt SHALL saturate at 15.
REQ-022 glitch_clr SHALL force glitch_cnt to 0 and SHALL win over a simultaneous increment.

Reset
REQ-023 While reset=1, the following SHALL be 0 on the next edge: state IDLE, counter, synchronizer flops, pulse, level and glitch_cnt.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse.
REQ-025 reset SHALL take priority over every other input.
REQ-026 If btn_raw is held high through reset release, it SHALL be treated as a new press, giving one pulse after the REQ-019 latency, counted from the first post-reset sample.

Configuration
REQ-027 Macro AUTOREPEAT_EN defined: a 16-bit hold counter SHALL count cycles spent in HIGH.
REQ-028 With AUTOREPEAT_EN, pulse SHALL assert for one cycle when the hold counter reaches HOLD_CYCLES, then every REPEAT_CYCLES cycles while in HIGH.
REQ-029 With AUTOREPEAT_EN, the hold counter SHALL clear on entry to HIGH from RISE_CHK and hold its value in FALL_CHK.
REQ-030 With AUTOREPEAT_EN, a FALL_CHK->HIGH bounce return SHALL resume the hold counter without restarting it.
REQ-031 Macro AUTOREPEAT_EN undefined: the hold counter SHALL be absent, and exactly one pulse per accepted press SHALL be produced.

Verification
REQ-032 Reset, then btn_raw 0->1 held 20 cycles, first sampled at edge 10 -> pulse=1 only in the cycle after edge 15; level=1 from then; glitch_cnt=0.
REQ-033 btn_raw high for 2 cycles then low (bounce) -> no pulse, level stays 0, glitch_cnt=1; repeat 20 bounces -> glitch_cnt=15 (saturated).
REQ-034 Pressed (level=1), btn_raw low 2 cycles then high -> level stays 1, no pulse, glitch_cnt+1; then low for 10 cycles -> level=0 after DEB_CYCLES+2 edges, no pulse.
REQ-035 glitch_clr=1 in the same cycle as a rejected bounce with glitch_cnt=7 -> glitch_cnt=0 next cycle.
REQ-036 Reset asserted at RISE_CHK counter=2 with btn_raw held high -> no pulse during reset; one pulse at release latency (edge R+5 after first post-reset sample R).
REQ-037 AUTOREPEAT_EN defined, defaults, press held 40 cycles after acceptance -> pulses at acceptance, +16, +24, +32, +40; undefined -> single pulse.
